// File: rtl/idu_pkg.sv
// idu_pkg: opcodes, instruction field positions, FSM states and helpers for idu_decode
package idu_pkg;
    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_ALUR  = 6'd1;
    localparam logic [5:0] OP_ALUI  = 6'd2;
    localparam logic [5:0] OP_LOAD  = 6'd3;
    localparam logic [5:0] OP_STORE = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_JMP   = 6'd7;
    localparam logic [5:0] OP_HALT  = 6'd63;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RD_HI = 25;
    localparam int RD_LO = 21;
    localparam int RA_HI = 20;
    localparam int RA_LO = 16;
    localparam int RB_HI = 15;
    localparam int RB_LO = 11;

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALTED} state_e;

    function automatic logic [63:0] sext16(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op <= OP_JMP || op == OP_HALT;
    endfunction
endpackage

// File: rtl/idu_branch_unit.sv
// idu_branch_unit: combinational branch compare, target computation, taken/halt flags
//   op_i     : opcode          idx_i    : instr[25:0] (imm16 in low half, jump index)
//   pc_i     : fetch PC (instr address + 1)
//   a_i, b_i : register operands for BEQ/BNE
//   taken_o  : BEQ/BNE/JMP redirect   halt_o : HALT   target_o : redirect address
module idu_branch_unit
    import idu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]      op_i,
    input  logic [25:0]     idx_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            taken_o,
    output logic            halt_o,
    output logic [XLEN-1:0] target_o
);
    logic eq;
    assign eq = a_i == b_i;
    always_comb begin
        taken_o  = (op_i == OP_BEQ && eq) || (op_i == OP_BNE && !eq) || op_i == OP_JMP;
        halt_o   = op_i == OP_HALT;
        // pc_i already points one past the instruction, so relative targets add directly
        target_o = halt_o ? pc_i - XLEN'(1) :
                   op_i == OP_JMP ? XLEN'(idx_i) : pc_i + XLEN'(sext16(idx_i[15:0]));
    end
endmodule

// File: rtl/idu_decode.sv
// idu_decode: decode/branch-resolve stage; redirects fetch and squashes wrong-path slots
//   clk, reset (async, active-low)
//   in_pc/in_instr             : fetched pair, instr lives at in_pc-1
//   rf_addr_a/b, rf_data_a/b   : same-cycle register file read
//   new_pc/set_pc              : combinational fetch redirect
//   out_*                      : registered decoded slot for execute
//   stat_taken/stat_squashed   : saturating counters, only with IDU_BRANCH_STATS_EN
module idu_decode
    import idu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic [4:0]      rf_addr_a,
    output logic [4:0]      rf_addr_b,
    input  logic [XLEN-1:0] rf_data_a,
    input  logic [XLEN-1:0] rf_data_b,
    output logic [XLEN-1:0] new_pc,
    output logic            set_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [5:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [10:0]     out_funct,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
`ifdef IDU_BRANCH_STATS_EN
    ,
    output logic [15:0]     stat_taken,
    output logic [15:0]     stat_squashed
`endif
);
    localparam int CW = $clog2(FLUSH_CYCLES + 2);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] halt_pc_q, halt_pc_d;
    logic [5:0]      op;
    logic            live, legal, taken, halt;
    logic [XLEN-1:0] target;

    assign op        = in_instr[OP_HI:OP_LO];
    assign live      = state_q == ST_RUN;
    assign legal     = is_legal(op);
    assign rf_addr_a = in_instr[RA_HI:RA_LO];
    assign rf_addr_b = op == OP_ALUR ? in_instr[RB_HI:RB_LO] : in_instr[RD_HI:RD_LO];

    idu_branch_unit #(.XLEN(XLEN)) u_bru (
        .op_i    (op),
        .idx_i   (in_instr[25:0]),
        .pc_i    (in_pc),
        .a_i     (rf_data_a),
        .b_i     (rf_data_b),
        .taken_o (taken),
        .halt_o  (halt),
        .target_o(target)
    );

    // Redirect is forced low while reset is held, even though the state already reads RUN
    assign set_pc = reset && (state_q == ST_HALTED || (live && (taken || halt)));
    assign new_pc = state_q == ST_HALTED ? halt_pc_q : target;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        halt_pc_d = halt_pc_q;
        if (state_q == ST_RUN) begin
            if (halt) begin
                state_d   = ST_HALTED;
                halt_pc_d = target;
            end else if (taken) begin
                cnt_d   = CW'(FLUSH_CYCLES);
                state_d = FLUSH_CYCLES == 0 ? ST_RUN : ST_FLUSH;
            end
        end else if (state_q == ST_FLUSH) begin
            cnt_d   = cnt_q - CW'(1);
            state_d = cnt_q == CW'(1) ? ST_RUN : ST_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            halt_pc_q   <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_op      <= OP_NOP;
            out_rd      <= '0;
            out_funct   <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pc_q   <= halt_pc_d;
            out_valid   <= live && legal;
            out_illegal <= live && !legal;
            out_op      <= live && legal ? op : OP_NOP;
            out_pc      <= in_pc - XLEN'(1);
            out_rd      <= in_instr[RD_HI:RD_LO];
            out_funct   <= in_instr[10:0];
            out_a       <= rf_data_a;
            out_b       <= rf_data_b;
            out_imm     <= XLEN'(sext16(in_instr[15:0]));
        end
    end

`ifdef IDU_BRANCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_taken    <= '0;
            stat_squashed <= '0;
        end else begin
            if (live && taken && !halt && stat_taken != 16'hFFFF)
                stat_taken <= stat_taken + 16'd1;
            if (state_q == ST_FLUSH && stat_squashed != 16'hFFFF)
                stat_squashed <= stat_squashed + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_idu_decode.sv
// tb_idu_decode: directed plus randomized checks of idu_decode against a behavioural model
module tb_idu_decode;
    localparam int FL = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_pc, in_instr, rf_data_a, rf_data_b, new_pc;
    logic [4:0]  rf_addr_a, rf_addr_b, out_rd;
    logic        set_pc, out_valid, out_illegal;
    logic [31:0] out_pc, out_a, out_b, out_imm;
    logic [5:0]  out_op;
    logic [10:0] out_funct;
`ifdef IDU_BRANCH_STATS_EN
    logic [15:0] stat_taken, stat_squashed;
`endif

    idu_decode #(.FLUSH_CYCLES(FL), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_pc(in_pc), .in_instr(in_instr),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .new_pc(new_pc), .set_pc(set_pc), .out_valid(out_valid), .out_pc(out_pc),
        .out_op(out_op), .out_rd(out_rd), .out_funct(out_funct), .out_a(out_a),
        .out_b(out_b), .out_imm(out_imm), .out_illegal(out_illegal)
`ifdef IDU_BRANCH_STATS_EN
        , .stat_taken(stat_taken), .stat_squashed(stat_squashed)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] regs [32];
    bit          halted;
    logic [31:0] halt_addr;
    int          squash_left, halt_cycles, n_taken, n_squash;
    logic        obs_set_pc;
    logic [31:0] obs_new_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        halted = 0; halt_addr = 0; squash_left = 0; halt_cycles = 0;
        n_taken = 0; n_squash = 0;
    endtask

    // Called just after a falling edge; presents one fetch slot and checks both sides of the edge
    task automatic step(input logic [31:0] pc, input logic [31:0] instr);
        logic [5:0]  op;
        logic [4:0]  ea, eb;
        logic [31:0] a, b, imm, tgt;
        logic        live, legal, tk, hl, eset;
        op    = instr[31:26];
        ea    = instr[20:16];
        eb    = op == 6'd1 ? instr[15:11] : instr[25:21];
        a     = regs[ea];
        b     = regs[eb];
        imm   = {{16{instr[15]}}, instr[15:0]};
        legal = op <= 6'd7 || op == 6'd63;
        live  = !halted && squash_left == 0;
        tk    = (op == 6'd5 && a == b) || (op == 6'd6 && a != b) || op == 6'd7;
        hl    = op == 6'd63;
        tgt   = hl ? pc - 32'd1 : op == 6'd7 ? {6'd0, instr[25:0]} : pc + imm;
        eset  = halted || (live && (tk || hl));
        in_pc = pc; in_instr = instr; rf_data_a = a; rf_data_b = b;
        #1;
        obs_set_pc = set_pc;
        obs_new_pc = new_pc;
        chk("rf_addr_a", rf_addr_a, ea);
        chk("rf_addr_b", rf_addr_b, eb);
        chk("set_pc", set_pc, eset);
        if (eset) chk("new_pc", new_pc, halted ? halt_addr : tgt);
        @(posedge clk); #1;
        chk("out_valid", out_valid, live && legal);
        chk("out_illegal", out_illegal, live && !legal);
        chk("out_op", out_op, (live && legal) ? op : 6'd0);
        if (live && legal) begin
            chk("out_pc", out_pc, pc - 32'd1);
            chk("out_rd", out_rd, instr[25:21]);
            chk("out_funct", out_funct, instr[10:0]);
            chk("out_a", out_a, a);
            chk("out_b", out_b, b);
            chk("out_imm", out_imm, imm);
        end
        if (halted) halt_cycles++;
        else if (squash_left > 0) begin squash_left--; n_squash++; end
        else if (hl) begin halted = 1; halt_addr = pc - 32'd1; end
        else if (tk) begin squash_left = FL; n_taken++; end
`ifdef IDU_BRANCH_STATS_EN
        chk("stat_taken", stat_taken, n_taken);
        chk("stat_squashed", stat_squashed, n_squash);
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_instr = {6'd7, 26'h123};
        #1;
        chk("rst_set_pc", set_pc, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_op", out_op, 6'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_illegal", out_illegal, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        int unsigned r, op;
        logic [31:0] w;
        r  = $urandom_range(0, 39);
        op = r < 8 ? r : r < 12 ? 5 : r < 16 ? 6 : r < 18 ? 7 :
             r < 20 ? $urandom_range(8, 62) : r == 20 ? 63 : $urandom_range(0, 4);
        w  = $urandom();
        w[31:26] = 6'(op);
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        model_reset();
        reset = 1'b0; in_pc = 0; in_instr = 0; rf_data_a = 0; rf_data_b = 0;
        @(posedge clk); @(negedge clk);
        do_reset();
        regs[1] = 32'd7; regs[2] = 32'd7;
        step(32'd1, 32'd0);
        step(32'd2, {6'd1, 5'd3, 5'd1, 5'd2, 11'd0});
        step(32'd5, {6'd5, 5'd2, 5'd1, 16'd8});
        chk("beq_target", obs_new_pc, 32'd13);
        step(32'd6, {6'd2, 26'h55});
        step(32'd14, 32'd0);
        step(32'd15, {6'd6, 5'd2, 5'd1, 16'd8});
        chk("bne_eq_no_redirect", obs_set_pc, 1'b0);
        step(32'd16, {6'd3, 26'h42});
        step(32'd3, {6'd5, 5'd2, 5'd1, 16'hFFFE});
        chk("beq_back_target", obs_new_pc, 32'd1);
        step(32'd4, 32'd0);
        step(32'd7, {6'd7, 26'h3FFFFFF});
        chk("jmp_target", obs_new_pc, 32'h03FFFFFF);
        step(32'd8, 32'd0);
        step(32'd20, {6'd8, 26'd0});
        step(32'd21, 32'd0);
        step(32'd10, {6'd63, 26'd0});
        chk("halt_target", obs_new_pc, 32'd9);
        for (int i = 0; i < 3; i++) step(32'd10 + 32'(i), {6'd5, 5'd2, 5'd1, 16'd4});
        chk("halted_hold", obs_new_pc, 32'd9);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (halt_cycles > 3) do_reset();
            regs[$urandom_range(0, 31)] = $urandom_range(0, 3);
            step($urandom(), rand_instr());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
